// File: rtl/inst_fetch_if_pkg.sv
// Shared definitions for the instruction-fetch bus stage: FSM states,
// the default AdEL exception bit index and the active reset level.
package inst_fetch_if_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT     = 3'd2,
        S_REQ_DROP = 3'd3,
        S_DROP     = 3'd4
    } fetch_state_t;

    localparam int   ADEL_CODE_IDX_DEF = 4;
    localparam logic RSTN_ENABLE       = 1'b0;

endpackage

// File: rtl/inst_fetch_if_out_buf.sv
// One-entry output register feeding if_id: clear beats load, load beats hold,
// and an unstalled cycle without a load empties the entry.
module inst_fetch_if_out_buf
    import inst_fetch_if_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              hold,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [DATA_W-1:0] load_inst,
    input  logic [31:0]       load_exc,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic [31:0]       exc
);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
            exc   <= '0;
        end else if (clear || (!load && !hold)) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
            exc   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
            exc   <= load_exc;
        end
    end

endmodule

// File: rtl/inst_fetch_if.sv
// Instruction-fetch bus stage: one outstanding SRAM-like request, flush-kill of
// in-flight fetches. Optional alignment check enabled by FETCH_ADEL_CHECK_EN.
module inst_fetch_if
    import inst_fetch_if_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int ADEL_CODE_IDX = ADEL_CODE_IDX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_vaddr_i,
    input  logic [31:0]       pc_excepttype_i,
    input  logic              stall,
    input  logic              flush,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              pc_read_ready,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_inst_o,
    output logic [31:0]       if_excepttype_o
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       exc_q;
    logic              latch;
    logic              bad_align;
    logic              adel_hold;
    logic              adel_load;
    logic              wait_load;
    logic              buf_load;

`ifdef FETCH_ADEL_CHECK_EN
    assign bad_align = |inst_vaddr_i[1:0];
    assign adel_load = (state == S_IDLE) && !stall && !flush && !adel_hold && bad_align;

    // A misaligned PC parks the stage until the exception flush arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            adel_hold <= 1'b0;
        end else if (flush) begin
            adel_hold <= 1'b0;
        end else if (adel_load) begin
            adel_hold <= 1'b1;
        end
    end
`else
    assign bad_align = 1'b0;
    assign adel_load = 1'b0;
    assign adel_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            state  <= S_IDLE;
            addr_q <= '0;
            exc_q  <= '0;
        end else begin
            state <= state_next;
            if (latch) begin
                addr_q <= inst_vaddr_i;
                exc_q  <= pc_excepttype_i;
            end
        end
    end

    always_comb begin
        state_next    = state;
        latch         = 1'b0;
        pc_read_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (!stall && !flush && !adel_hold && !bad_align) begin
                    latch      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (inst_addr_ok) begin
                    pc_read_ready = !flush;
                    state_next    = flush ? S_DROP : S_WAIT;
                end else if (flush) begin
                    state_next = S_REQ_DROP;
                end
            end
            S_REQ_DROP: begin
                if (inst_addr_ok) state_next = S_DROP;
            end
            S_WAIT: begin
                // Back-to-back launch straight from the data cycle; a misaligned
                // next PC is left for IDLE to report.
                if (inst_data_ok) begin
                    if (!stall && !flush && !bad_align) begin
                        latch      = 1'b1;
                        state_next = S_REQ;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (flush) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (inst_data_ok) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign inst_req  = (state == S_REQ) || (state == S_REQ_DROP);
    assign inst_addr = addr_q;
    assign wait_load = (state == S_WAIT) && inst_data_ok && !flush;
    assign buf_load  = wait_load || adel_load;

    inst_fetch_if_out_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .load      (buf_load),
        .hold      (stall),
        .load_pc   (adel_load ? inst_vaddr_i : addr_q),
        .load_inst (adel_load ? '0 : inst_rdata),
        .load_exc  (adel_load ? (pc_excepttype_i | (32'd1 << ADEL_CODE_IDX)) : exc_q),
        .valid     (if_valid_o),
        .pc        (if_pc_o),
        .inst      (if_inst_o),
        .exc       (if_excepttype_o)
    );

endmodule

// File: tb/tb_inst_fetch_if.sv
// Scoreboard bench for inst_fetch_if: stimulus pushes expected words and
// pc_read_ready addresses; a negedge monitor pops and compares them.
module tb_inst_fetch_if;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exc;
    } word_t;

    logic        clk;
    logic        rst;
    logic [31:0] inst_vaddr_i;
    logic [31:0] pc_excepttype_i;
    logic        stall;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        pc_read_ready;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_excepttype_o;

    word_t       exp_words[$];
    logic [31:0] exp_ready[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic        prev_valid    = 1'b0;
    logic        stall_at_edge = 1'b1;

    inst_fetch_if dut (
        .clk             (clk),
        .rst             (rst),
        .inst_vaddr_i    (inst_vaddr_i),
        .pc_excepttype_i (pc_excepttype_i),
        .stall           (stall),
        .flush           (flush),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .pc_read_ready   (pc_read_ready),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_excepttype_o (if_excepttype_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic applyStimulus(input logic s, input logic f, input logic [31:0] va,
                                 input logic [31:0] ex, input logic aok, input logic dok,
                                 input logic [31:0] rd);
        stall           = s;
        flush           = f;
        inst_vaddr_i    = va;
        pc_excepttype_i = ex;
        inst_addr_ok    = aok;
        inst_data_ok    = dok;
        inst_rdata      = rd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] exc);
        word_t w;
        w.pc   = pc;
        w.inst = inst;
        w.exc  = exc;
        exp_words.push_back(w);
    endtask

    // The entry is freshly presented when it was empty before or the last edge was unstalled.
    always @(posedge clk) stall_at_edge = stall;

    always @(negedge clk) begin
        if (rst) begin
            if (if_valid_o && (!prev_valid || !stall_at_edge)) begin
                if (exp_words.size() == 0) begin
                    checkOutput("unexpected_word_queue_depth", 32'(exp_words.size()), 32'd1);
                end else begin
                    word_t w;
                    w = exp_words.pop_front();
                    checkOutput("word_pc", if_pc_o, w.pc);
                    checkOutput("word_inst", if_inst_o, w.inst);
                    checkOutput("word_exc", if_excepttype_o, w.exc);
                end
            end
            if (pc_read_ready) begin
                if (exp_ready.size() == 0) begin
                    checkOutput("unexpected_ready_queue_depth", 32'(exp_ready.size()), 32'd1);
                end else begin
                    checkOutput("ready_addr", inst_addr, exp_ready.pop_front());
                end
            end
            prev_valid = if_valid_o;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        applyStimulus(1, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_inst_req", 32'(inst_req), 32'd0);
        checkOutput("rst_inst_addr", inst_addr, 32'h0);
        checkOutput("rst_ready", 32'(pc_read_ready), 32'd0);
        checkOutput("rst_valid", 32'(if_valid_o), 32'd0);
        checkOutput("rst_pc", if_pc_o, 32'h0);
        checkOutput("rst_inst", if_inst_o, 32'h0);
        checkOutput("rst_exc", if_excepttype_o, 32'h0);
        nextCycle();
        rst = 1'b1;

        // Basic fetch, addr_ok immediately and data_ok one cycle later
        applyStimulus(0, 0, 32'hbfc00000, 32'h0, 0, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 32'hbfc00004, 32'h0, 1, 0, 32'h0);
        exp_ready.push_back(32'hbfc00000);
        @(negedge clk);
        checkOutput("t1_req", 32'(inst_req), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 32'hbfc00004, 32'h0, 0, 1, 32'h24080001);
        pushWord(32'hbfc00000, 32'h24080001, 32'h0);
        @(negedge clk);
        checkOutput("t1_ready_single_pulse", 32'(pc_read_ready), 32'd0);
        nextCycle();

        // addr_ok held low for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 32'hbfc00008, 32'h0, 0, 0, 32'h0);
            @(negedge clk);
            checkOutput("t2_req_held", 32'(inst_req), 32'd1);
            checkOutput("t2_addr_stable", inst_addr, 32'hbfc00004);
            checkOutput("t2_ready_low", 32'(pc_read_ready), 32'd0);
            nextCycle();
        end
        applyStimulus(0, 0, 32'hbfc00008, 32'h0, 1, 0, 32'h0);
        exp_ready.push_back(32'hbfc00004);
        @(negedge clk);
        checkOutput("t2_req_at_accept", 32'(inst_req), 32'd1);
        nextCycle();

        // Flush in WAIT; the late word must be dropped
        applyStimulus(0, 1, 32'hbfc00008, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("t3_valid_at_flush", 32'(if_valid_o), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 32'hbfc00380, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("t3_no_req_in_drop", 32'(inst_req), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 32'hbfc00380, 32'h0, 0, 1, 32'h8c010004);
        @(negedge clk);
        checkOutput("t3_valid_before_data", 32'(if_valid_o), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 32'hbfc00380, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("t3_word_dropped", 32'(if_valid_o), 32'd0);
        nextCycle();

        // Flush in REQ with addr_ok low
        applyStimulus(0, 1, 32'hbfc00380, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("t3_new_pc_req", 32'(inst_req), 32'd1);
        checkOutput("t3_new_pc_addr", inst_addr, 32'hbfc00380);
        checkOutput("t4_ready_flush", 32'(pc_read_ready), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 32'hbfc00380, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("t4_req_kept", 32'(inst_req), 32'd1);
        checkOutput("t4_addr_kept", inst_addr, 32'hbfc00380);
        nextCycle();
        applyStimulus(0, 0, 32'hbfc00380, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        checkOutput("t4_ready_killed", 32'(pc_read_ready), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 32'hbfc00384, 32'h100, 0, 1, 32'hdeadbeef);
        @(negedge clk);
        checkOutput("t4_no_req_drop", 32'(inst_req), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 32'hbfc00384, 32'h100, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("t4_word_dropped", 32'(if_valid_o), 32'd0);
        nextCycle();

        // Stall held over a valid output
        applyStimulus(0, 0, 32'hbfc00388, 32'h0, 1, 0, 32'h0);
        exp_ready.push_back(32'hbfc00384);
        nextCycle();
        applyStimulus(1, 0, 32'hbfc00388, 32'h0, 0, 1, 32'h11111111);
        pushWord(32'hbfc00384, 32'h11111111, 32'h100);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 32'hbfc00388, 32'h0, 0, 0, 32'h0);
            @(negedge clk);
            checkOutput("t5_valid_hold", 32'(if_valid_o), 32'd1);
            checkOutput("t5_pc_hold", if_pc_o, 32'hbfc00384);
            checkOutput("t5_inst_hold", if_inst_o, 32'h11111111);
            checkOutput("t5_no_req", 32'(inst_req), 32'd0);
            nextCycle();
        end
        applyStimulus(0, 0, 32'hbfc00388, 32'h0, 0, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 32'hbfc00388, 32'h0, 1, 0, 32'h0);
        exp_ready.push_back(32'hbfc00388);
        @(negedge clk);
        checkOutput("t5_relaunch_req", 32'(inst_req), 32'd1);
        checkOutput("t5_relaunch_addr", inst_addr, 32'hbfc00388);
        checkOutput("t5_cleared", 32'(if_valid_o), 32'd0);
        nextCycle();
        applyStimulus(1, 0, 32'hbfc00388, 32'h0, 0, 1, 32'h22222222);
        pushWord(32'hbfc00388, 32'h22222222, 32'h0);
        nextCycle();

        // Misaligned PC
        applyStimulus(0, 0, 32'hbfc00002, 32'h0, 0, 0, 32'h0);
`ifdef FETCH_ADEL_CHECK_EN
        pushWord(32'hbfc00002, 32'h0, 32'h10);
        nextCycle();
        applyStimulus(0, 1, 32'hbfc00002, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("t6_adel_no_req", 32'(inst_req), 32'd0);
        nextCycle();
        applyStimulus(1, 0, 32'hbfc00002, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("t6_adel_idle_no_req", 32'(inst_req), 32'd0);
        nextCycle();
`else
        nextCycle();
        applyStimulus(0, 1, 32'hbfc00002, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        checkOutput("t6_misaligned_req", 32'(inst_req), 32'd1);
        checkOutput("t6_misaligned_addr", inst_addr, 32'hbfc00002);
        checkOutput("t6_ready_under_flush", 32'(pc_read_ready), 32'd0);
        nextCycle();
        applyStimulus(1, 0, 32'hbfc00002, 32'h0, 0, 1, 32'h33333333);
        nextCycle();
        applyStimulus(1, 0, 32'hbfc00002, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("t6_idle_no_req", 32'(inst_req), 32'd0);
        checkOutput("t6_word_dropped", 32'(if_valid_o), 32'd0);
        nextCycle();
`endif

        repeat (3) nextCycle();
        checkOutput("words_outstanding", 32'(exp_words.size()), 32'd0);
        checkOutput("ready_outstanding", 32'(exp_ready.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
